// File: rtl/buf_rd_streamer.sv
// -----------------------------------------------------------------------------
// buf_rd_streamer
//
// Purpose:
//   Reads a run of consecutive words from a synchronous buffer (1-cycle read
//   latency) and presents them as a valid/ready output stream. A 2-entry output
//   FIFO absorbs back-pressure. Reads are only issued when the FIFO plus the one
//   read in flight can still hold the returning word, so no data is ever lost.
//   With m_ready held high the stream runs at one beat per clock.
//
// Ports:
//   clk          - single clock for all logic
//   rst_n        - asynchronous active-low reset
//   start        - one-cycle transfer request (accepted only while idle)
//   base_addr    - first word address, sampled with start
//   len          - number of words to read, sampled with start (0 = no beats)
//   busy         - transfer in progress (state != IDLE)
//   done         - one-cycle pulse after the final beat (or after a len=0 start)
//   buf_ex_addr  - registered read address to the buffer
//   buf_ex_data  - buffer read data, valid one cycle after its address
//   m_valid      - output stream valid (FIFO not empty)
//   m_ready      - output stream ready
//   m_data       - output stream data (FIFO head)
//   m_last       - marks the final beat of the transfer
//   stall_cnt    - (BUF_RD_STREAMER_STATS_EN only) cycles with m_valid & !m_ready
//
// Configuration:
//   BUF_RD_STREAMER_STATS_EN - when defined, adds the 32-bit saturating
//                              stall_cnt output and its counter.
// -----------------------------------------------------------------------------
module buf_rd_streamer #(
    parameter int BUF_EX_ADDR_WIDTH = 8,
    parameter int BUF_EX_DATA_WIDTH = 256,
    parameter int LEN_WIDTH         = BUF_EX_ADDR_WIDTH + 1
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         start,
    input  logic [BUF_EX_ADDR_WIDTH-1:0] base_addr,
    input  logic [LEN_WIDTH-1:0]         len,
    output logic                         busy,
    output logic                         done,
    output logic [BUF_EX_ADDR_WIDTH-1:0] buf_ex_addr,
    input  logic [BUF_EX_DATA_WIDTH-1:0] buf_ex_data,
    output logic                         m_valid,
    input  logic                         m_ready,
    output logic [BUF_EX_DATA_WIDTH-1:0] m_data,
    output logic                         m_last
`ifdef BUF_RD_STREAMER_STATS_EN
    ,
    output logic [31:0]                  stall_cnt
`endif
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t                         state_q, state_d;

    logic [BUF_EX_ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic [LEN_WIDTH-1:0]           len_q, len_d;
    logic [LEN_WIDTH-1:0]           issue_cnt_q, issue_cnt_d;
    logic [LEN_WIDTH-1:0]           beat_cnt_q, beat_cnt_d;
    logic                           inflight_q, inflight_d;
    logic                           done_q, done_d;

    logic [BUF_EX_DATA_WIDTH-1:0]   fifo_mem_q [2];
    logic                           wr_ptr_q, wr_ptr_d;
    logic                           rd_ptr_q, rd_ptr_d;
    logic [1:0]                     count_q, count_d;

    logic                           start_acc;
    logic                           start_run;
    logic                           start_zero;
    logic                           push;
    logic                           pop;
    logic                           last_pop;
    logic                           issue;
    logic                           last_issue;
    logic [2:0]                     occupancy;

    // -------------------------------------------------------------------------
    // Request decode
    // -------------------------------------------------------------------------
    assign start_acc  = start && (state_q == IDLE);
    assign start_run  = start_acc && (len != '0);
    assign start_zero = start_acc && (len == '0);

    assign pop      = m_valid && m_ready;
    assign last_pop = pop && m_last;
    assign push     = inflight_q;

    // Words already owed to the FIFO after this cycle's pop: stored entries plus
    // the read whose data arrives this cycle. pop implies count_q >= 1, so this
    // never underflows.
    assign occupancy = {1'b0, count_q} + {2'b00, inflight_q} - {2'b00, pop};

    // -------------------------------------------------------------------------
    // FSM: state register
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // -------------------------------------------------------------------------
    // FSM: next-state logic
    // -------------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (start_run)  state_d = RUN;
            RUN:     if (last_issue) state_d = DRAIN;
            DRAIN:   if (last_pop)   state_d = IDLE;
            default:                 state_d = IDLE;
        endcase
    end

    // -------------------------------------------------------------------------
    // FSM: outputs
    // -------------------------------------------------------------------------
    always_comb begin
        busy       = (state_q != IDLE);
        // RUN is left right after the len-th issue, so while in RUN there is
        // always at least one word still to request.
        issue      = (state_q == RUN) && (occupancy < 3'd2);
        last_issue = issue && ((issue_cnt_q + LEN_WIDTH'(1)) == len_q);
    end

    // -------------------------------------------------------------------------
    // Stage 0: address issue and transfer bookkeeping
    // -------------------------------------------------------------------------
    always_comb begin
        addr_d      = addr_q;
        len_d       = len_q;
        issue_cnt_d = issue_cnt_q;
        beat_cnt_d  = beat_cnt_q;
        inflight_d  = issue;
        done_d      = start_zero || last_pop;

        if (start_run) begin
            addr_d      = base_addr;
            len_d       = len;
            issue_cnt_d = '0;
            beat_cnt_d  = '0;
        end else begin
            if (issue) begin
                // Natural wrap modulo 2^BUF_EX_ADDR_WIDTH.
                addr_d      = addr_q + BUF_EX_ADDR_WIDTH'(1);
                issue_cnt_d = issue_cnt_q + LEN_WIDTH'(1);
            end
            if (pop) begin
                beat_cnt_d = beat_cnt_q + LEN_WIDTH'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_q      <= '0;
            len_q       <= '0;
            issue_cnt_q <= '0;
            beat_cnt_q  <= '0;
            inflight_q  <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            addr_q      <= addr_d;
            len_q       <= len_d;
            issue_cnt_q <= issue_cnt_d;
            beat_cnt_q  <= beat_cnt_d;
            inflight_q  <= inflight_d;
            done_q      <= done_d;
        end
    end

    assign buf_ex_addr = addr_q;
    assign done        = done_q;

    // -------------------------------------------------------------------------
    // Stage 1: returning read data into the 2-entry FIFO
    // -------------------------------------------------------------------------
    always_comb begin
        wr_ptr_d = push ? ~wr_ptr_q : wr_ptr_q;
        rd_ptr_d = pop  ? ~rd_ptr_q : rd_ptr_q;
        count_d  = count_q + {1'b0, push} - {1'b0, pop};
    end

    // Storage is cleared on reset so m_data reads back as zero afterwards.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fifo_mem_q[0] <= '0;
            fifo_mem_q[1] <= '0;
            wr_ptr_q      <= 1'b0;
            rd_ptr_q      <= 1'b0;
            count_q       <= 2'd0;
        end else begin
            if (push) begin
                fifo_mem_q[wr_ptr_q] <= buf_ex_data;
            end
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // -------------------------------------------------------------------------
    // Stage 2: FIFO head to the output stream
    // -------------------------------------------------------------------------
    assign m_valid = (count_q != 2'd0);
    assign m_data  = fifo_mem_q[rd_ptr_q];
    // Beats leave in order, so the pop counter identifies the head beat.
    assign m_last  = m_valid && ((beat_cnt_q + LEN_WIDTH'(1)) == len_q);

`ifdef BUF_RD_STREAMER_STATS_EN
    // -------------------------------------------------------------------------
    // Back-pressure statistics
    // -------------------------------------------------------------------------
    logic [31:0] stall_q, stall_d;

    always_comb begin
        stall_d = stall_q;
        if (start_acc) begin
            stall_d = '0;
        end else if (m_valid && !m_ready && (stall_q != 32'hFFFF_FFFF)) begin
            stall_d = stall_q + 32'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_q <= '0;
        end else begin
            stall_q <= stall_d;
        end
    end

    assign stall_cnt = stall_q;
`endif

endmodule

// File: tb/tb_buf_rd_streamer.sv
// -----------------------------------------------------------------------------
// tb_buf_rd_streamer
//
// Directed bench for buf_rd_streamer. A behavioural buffer returns
// memval(addr) one cycle after each address. Inputs are driven and outputs
// sampled 1 time unit after the rising edge.
// -----------------------------------------------------------------------------
module tb_buf_rd_streamer;

    localparam int AW = 8;
    localparam int DW = 256;
    localparam int LW = AW + 1;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          start;
    logic [AW-1:0] base_addr;
    logic [LW-1:0] len;
    logic          busy;
    logic          done;
    logic [AW-1:0] buf_ex_addr;
    logic [DW-1:0] buf_ex_data;
    logic          m_valid;
    logic          m_ready;
    logic [DW-1:0] m_data;
    logic          m_last;
`ifdef BUF_RD_STREAMER_STATS_EN
    logic [31:0]   stall_cnt;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    buf_rd_streamer #(
        .BUF_EX_ADDR_WIDTH(AW),
        .BUF_EX_DATA_WIDTH(DW),
        .LEN_WIDTH        (LW)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .base_addr  (base_addr),
        .len        (len),
        .busy       (busy),
        .done       (done),
        .buf_ex_addr(buf_ex_addr),
        .buf_ex_data(buf_ex_data),
        .m_valid    (m_valid),
        .m_ready    (m_ready),
        .m_data     (m_data),
        .m_last     (m_last)
`ifdef BUF_RD_STREAMER_STATS_EN
        ,
        .stall_cnt  (stall_cnt)
`endif
    );

    function automatic logic [DW-1:0] memval(input logic [AW-1:0] a);
        return {16{a, ~a}};
    endfunction

    // Buffer model: one-cycle read latency.
    always @(posedge clk) buf_ex_data <= memval(buf_ex_addr);

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; start = 1'b0; m_ready = 1'b0; base_addr = '0; len = '0;
        #3;
        checks++;
        if ({busy, done, m_valid, m_last} !== 4'b0000 || buf_ex_addr !== '0 || m_data !== '0) begin
            errors++;
            $display("FAIL reset_async: busy=%b done=%b v=%b last=%b addr=%h data_nz=%b, want all 0",
                     busy, done, m_valid, m_last, buf_ex_addr, (m_data != '0));
        end
        step(); step();
        checks++;
        if ({busy, done, m_valid, m_last} !== 4'b0000 || buf_ex_addr !== '0) begin
            errors++;
            $display("FAIL reset_held: busy=%b done=%b v=%b last=%b addr=%h, want all 0",
                     busy, done, m_valid, m_last, buf_ex_addr);
        end
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_basic();
        logic ev, el, ed, eb;
        m_ready = 1'b1; base_addr = 8'h10; len = LW'(4); start = 1'b1;
        step();
        start = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            ev = (k >= 3 && k <= 6); el = (k == 6); ed = (k == 7); eb = (k <= 6);
            checks++;
            if (m_valid !== ev || m_last !== el || done !== ed || busy !== eb) begin
                errors++;
                $display("FAIL basic_ctrl t+%0d: v=%b last=%b done=%b busy=%b, want v=%b last=%b done=%b busy=%b",
                         k, m_valid, m_last, done, busy, ev, el, ed, eb);
            end
            if (ev) begin
                checks++;
                if (m_data !== memval(AW'(32'h10 + k - 3))) begin
                    errors++;
                    $display("FAIL basic_data t+%0d: got %h want %h", k, m_data[15:0], 16'(memval(AW'(32'h10 + k - 3))));
                end
            end
            if (k == 1) begin
                checks++;
                if (buf_ex_addr !== 8'h10) begin
                    errors++;
                    $display("FAIL basic_first_addr: got %h want 10", buf_ex_addr);
                end
            end
            if (k < 8) step();
        end
    endtask

    task automatic test_back_to_back();
        int  n;
        logic ev, el, ed;
        m_ready = 1'b1; base_addr = 8'h20; len = LW'(2); start = 1'b1;
        step();
        start = 1'b0;
        n = 0;
        while (done !== 1'b1 && n < 20) begin step(); n++; end
        checks++;
        if (done !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL b2b_first_done: done=%b busy=%b, want done=1 busy=0", done, busy);
        end
        // New start in the same cycle as done.
        base_addr = 8'h60; len = LW'(3); start = 1'b1;
        step();
        start = 1'b0;
        for (int k = 1; k <= 6; k++) begin
            ev = (k >= 3 && k <= 5); el = (k == 5); ed = (k == 6);
            checks++;
            if (m_valid !== ev || m_last !== el || done !== ed || busy !== (k <= 5)) begin
                errors++;
                $display("FAIL b2b_ctrl t+%0d: v=%b last=%b done=%b busy=%b, want v=%b last=%b done=%b",
                         k, m_valid, m_last, done, busy, ev, el, ed);
            end
            if (ev) begin
                checks++;
                if (m_data !== memval(AW'(32'h60 + k - 3))) begin
                    errors++;
                    $display("FAIL b2b_data t+%0d: got %h want %h", k, m_data[15:0], 16'(memval(AW'(32'h60 + k - 3))));
                end
            end
            if (k < 6) step();
        end
    endtask

    task automatic test_wrap();
        logic [AW-1:0] ea;
        m_ready = 1'b1; base_addr = 8'hFE; len = LW'(4); start = 1'b1;
        step();
        start = 1'b0;
        for (int k = 1; k <= 7; k++) begin
            if (k <= 4) begin
                ea = AW'(32'hFE + k - 1);
                checks++;
                if (buf_ex_addr !== ea) begin
                    errors++;
                    $display("FAIL wrap_addr t+%0d: got %h want %h", k, buf_ex_addr, ea);
                end
            end
            if (k >= 3 && k <= 6) begin
                ea = AW'(32'hFE + k - 3);
                checks++;
                if (m_valid !== 1'b1 || m_data !== memval(ea) || m_last !== (k == 6)) begin
                    errors++;
                    $display("FAIL wrap_beat t+%0d: v=%b data=%h last=%b, want v=1 data=%h last=%b",
                             k, m_valid, m_data[15:0], m_last, 16'(memval(ea)), (k == 6));
                end
            end
            if (k == 7) begin
                checks++;
                if (done !== 1'b1 || m_valid !== 1'b0) begin
                    errors++;
                    $display("FAIL wrap_done: done=%b v=%b, want done=1 v=0", done, m_valid);
                end
            end
            if (k < 7) step();
        end
    endtask

    task automatic test_random_ready();
        int            beats, stalls, max_out, outstanding, n;
        logic          have_hold, seen_done;
        logic [DW-1:0] hold_data;
        beats = 0; stalls = 0; max_out = 0; n = 0; have_hold = 1'b0; seen_done = 1'b0;
        hold_data = '0;
        m_ready = 1'b0; base_addr = 8'hA0; len = LW'(8); start = 1'b1;
        step();
        start = 1'b0;
        while (!seen_done && n < 200) begin
            m_ready = 1'($urandom_range(0, 1));
            if (have_hold) begin
                checks++;
                if (m_valid !== 1'b1 || m_data !== hold_data) begin
                    errors++;
                    $display("FAIL rand_stable beat %0d: v=%b data=%h, want v=1 data=%h",
                             beats, m_valid, m_data[15:0], hold_data[15:0]);
                end
            end
            outstanding = int'(AW'(buf_ex_addr - 8'hA0)) - beats;
            if (outstanding > max_out) max_out = outstanding;
            if (m_valid && m_ready) begin
                checks++;
                if (m_data !== memval(AW'(32'hA0 + beats)) || m_last !== (beats == 7)) begin
                    errors++;
                    $display("FAIL rand_beat %0d: data=%h last=%b, want data=%h last=%b",
                             beats, m_data[15:0], m_last, 16'(memval(AW'(32'hA0 + beats))), (beats == 7));
                end
                beats++;
                have_hold = 1'b0;
            end else if (m_valid) begin
                stalls++;
                have_hold = 1'b1;
                hold_data = m_data;
            end else begin
                have_hold = 1'b0;
            end
            if (done === 1'b1) seen_done = 1'b1;
            else begin step(); n++; end
        end
        checks++;
        if (!seen_done || beats != 8) begin
            errors++;
            $display("FAIL rand_count: done_seen=%b beats=%0d, want done_seen=1 beats=8", seen_done, beats);
        end
        checks++;
        if (max_out > 2) begin
            errors++;
            $display("FAIL rand_buffered: max outstanding=%0d, want <=2", max_out);
        end
`ifdef BUF_RD_STREAMER_STATS_EN
        checks++;
        if (stall_cnt !== 32'(stalls)) begin
            errors++;
            $display("FAIL rand_stall_cnt: got %0d want %0d", stall_cnt, stalls);
        end
`endif
        m_ready = 1'b1;
        step();
    endtask

    task automatic test_zero_len_and_busy_start();
        int n, beats;
        m_ready = 1'b1; base_addr = 8'h33; len = '0; start = 1'b1;
        step();
        start = 1'b0;
        checks++;
        if (done !== 1'b1 || busy !== 1'b0 || m_valid !== 1'b0) begin
            errors++;
            $display("FAIL zero_done: done=%b busy=%b v=%b, want done=1 busy=0 v=0", done, busy, m_valid);
        end
        for (int k = 0; k < 4; k++) begin
            step();
            checks++;
            if (done !== 1'b0 || m_valid !== 1'b0 || busy !== 1'b0) begin
                errors++;
                $display("FAIL zero_quiet %0d: done=%b v=%b busy=%b, want 0 0 0", k, done, m_valid, busy);
            end
        end
        // Start while busy must be ignored.
        base_addr = 8'h40; len = LW'(3); start = 1'b1;
        step();
        start = 1'b0;
        step();
        base_addr = 8'h80; len = LW'(5); start = 1'b1;
        step();
        start = 1'b0;
        beats = 0; n = 0;
        while (done !== 1'b1 && n < 30) begin
            if (m_valid && m_ready) begin
                checks++;
                if (m_data !== memval(AW'(32'h40 + beats))) begin
                    errors++;
                    $display("FAIL busy_start_data beat %0d: got %h want %h",
                             beats, m_data[15:0], 16'(memval(AW'(32'h40 + beats))));
                end
                beats++;
            end
            step(); n++;
        end
        checks++;
        if (done !== 1'b1 || beats != 3) begin
            errors++;
            $display("FAIL busy_start_count: done=%b beats=%0d, want done=1 beats=3", done, beats);
        end
        for (int k = 0; k < 6; k++) begin
            step();
            checks++;
            if (m_valid !== 1'b0 || busy !== 1'b0) begin
                errors++;
                $display("FAIL busy_start_after %0d: v=%b busy=%b, want 0 0", k, m_valid, busy);
            end
        end
    endtask

    task automatic test_reset_mid_transfer();
        logic ev;
        m_ready = 1'b1; base_addr = 8'h30; len = LW'(6); start = 1'b1;
        step();
        start = 1'b0;
        step(); step(); step(); step();  // t+5: beat index 2 on the bus
        checks++;
        if (m_valid !== 1'b1 || m_data !== memval(8'h32)) begin
            errors++;
            $display("FAIL rst_mid_beat2: v=%b data=%h, want v=1 data=%h", m_valid, m_data[15:0], 16'(memval(8'h32)));
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if ({busy, done, m_valid, m_last} !== 4'b0000 || buf_ex_addr !== '0 || m_data !== '0) begin
            errors++;
            $display("FAIL rst_mid_immediate: busy=%b done=%b v=%b last=%b addr=%h data_nz=%b, want all 0",
                     busy, done, m_valid, m_last, buf_ex_addr, (m_data != '0));
        end
        step(); step();
        rst_n = 1'b1;
        for (int k = 0; k < 6; k++) begin
            step();
            checks++;
            if (done !== 1'b0 || m_valid !== 1'b0 || busy !== 1'b0) begin
                errors++;
                $display("FAIL rst_mid_quiet %0d: done=%b v=%b busy=%b, want 0 0 0", k, done, m_valid, busy);
            end
        end
        base_addr = 8'h50; len = LW'(2); start = 1'b1;
        step();
        start = 1'b0;
        for (int k = 1; k <= 5; k++) begin
            ev = (k == 3 || k == 4);
            checks++;
            if (m_valid !== ev || m_last !== (k == 4) || done !== (k == 5)) begin
                errors++;
                $display("FAIL rst_restart t+%0d: v=%b last=%b done=%b, want v=%b last=%b done=%b",
                         k, m_valid, m_last, done, ev, (k == 4), (k == 5));
            end
            if (ev) begin
                checks++;
                if (m_data !== memval(AW'(32'h50 + k - 3))) begin
                    errors++;
                    $display("FAIL rst_restart_data t+%0d: got %h want %h",
                             k, m_data[15:0], 16'(memval(AW'(32'h50 + k - 3))));
                end
            end
            if (k < 5) step();
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_back_to_back();
        test_wrap();
        test_random_ready();
        test_zero_len_and_busy_start();
        test_reset_mid_transfer();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/buf_rd_streamer.md
BUF_RD_STREAMER -- requirements
Module: buf_rd_streamer

Interface
REQ-001 SHALL have parameter BUF_EX_ADDR_WIDTH, default 8: read address width of the downstream-facing buffer port.
REQ-002 SHALL have parameter BUF_EX_DATA_WIDTH, default 256: read data width.
REQ-003 SHALL have parameter LEN_WIDTH, default BUF_EX_ADDR_WIDTH+1: transfer length field width.
REQ-004 SHALL have port clk, input, 1: the single clock for all logic.
REQ-005 SHALL have port rst_n, input, 1: asynchronous, active-low reset.
REQ-006 SHALL have port start, input, 1: single-cycle request to begin a transfer.
REQ-007 SHALL have port base_addr, input, BUF_EX_ADDR_WIDTH: first word address, sampled with start.
REQ-008 SHALL have port len, input, LEN_WIDTH: number of words to read, sampled with start.
REQ-009 SHALL have port busy, output, 1: transfer in progress.
REQ-010 SHALL have port done, output, 1: one-cycle completion pulse.
REQ-011 SHALL have port buf_ex_addr, output, BUF_EX_ADDR_WIDTH: registered read address to the buffer.
REQ-012 SHALL have port buf_ex_data, input, BUF_EX_DATA_WIDTH: buffer read data, valid exactly 1 cycle after its address.
REQ-013 SHALL have ports m_valid (output, 1), m_ready (input, 1), m_data (output, BUF_EX_DATA_WIDTH), and m_last (output, 1) forming the output stream.

Function
REQ-014 SHALL implement states IDLE, RUN and DRAIN; busy = (state != IDLE).
REQ-015 SHALL accept start only in IDLE; start while busy SHALL be ignored with no side effects.
REQ-016 SHALL, on start with len=0, stay in IDLE, emit no beats, and pulse done on the next cycle.
REQ-017 SHALL, on start with len>0, enter RUN; the first read SHALL issue in the cycle after start with buf_ex_addr = base_addr.
REQ-018 SHALL increment buf_ex_addr by 1 per issued read, wrapping modulo 2^BUF_EX_ADDR_WIDTH (e.g. 0xFF -> 0x00).
REQ-019 SHALL issue a read only when (fifo_count + inflight - pop_this_cycle) < 2, where pop = m_valid & m_ready.
REQ-020 SHALL write buf_ex_data into a 2-entry output FIFO in the cycle after each issue; inflight <= 1 at all times.
REQ-021 SHALL drive m_valid = FIFO non-empty and m_data = FIFO head, which SHALL stay stable while m_valid & !m_ready.
REQ-022 SHALL assert m_last with the final beat (beat index len-1) only.
REQ-023 SHALL move RUN -> DRAIN after the len-th issue, and DRAIN -> IDLE on the m_last handshake.
REQ-024 SHALL pulse done, and deassert busy, in the cycle after the m_last handshake.
REQ-025 SHALL have a latency of 3 cycles from start (cycle t) to first m_valid (t+3), and sustain 1 beat/cycle when m_ready is held high.
REQ-026 SHALL accept a new start in the same cycle done is high.

Reset
REQ-027 SHALL, while rst_n is low, asynchronously force state=IDLE, busy=0, done=0, m_valid=0, m_last=0, buf_ex_addr=0, FIFO empty, inflight=0, and beat/issue counters=0.
REQ-028 SHALL, on reset assertion mid-transfer, abort the transfer: no done pulse, no further beats, and read data returning after reset discarded.
REQ-029 SHALL reset m_data to 0.

Configuration
REQ-030 SHALL, with macro BUF_RD_STREAMER_STATS_EN defined, add output stall_cnt (32 bits) counting cycles with m_valid & !m_ready, cleared on accepted start and on reset, and saturating at 0xFFFFFFFF.
REQ-031 SHALL, without BUF_RD_STREAMER_STATS_EN, omit the stall_cnt port and its logic entirely, with all other behaviour identical.

Verification
REQ-032 Bench SHALL cover: base=0x10, len=4, m_ready=1 -> m_valid at t+3..t+6, data = mem[0x10..0x13], m_last on 4th beat, done at t+7.
REQ-033 Bench SHALL cover: base=0xFE, len=4 -> addresses 0xFE, 0xFF, 0x00, 0x01 issued, data order preserved.
REQ-034 Bench SHALL cover: len=8 with m_ready toggling at random 50% -> exactly 8 beats in order, m_data stable while stalled, at most 2 entries buffered, and stall_cnt equal to the counted stall cycles when STATS_EN is defined.
REQ-035 Bench SHALL cover: len=0 -> done 1 cycle later, m_valid never high; and start during busy -> ignored, beat count unchanged.
REQ-036 Bench SHALL cover: rst_n low at beat 2 of len=6 -> all outputs 0 immediately, no done, and a new start (len=2) after release completes correctly.
